// File: rtl/seq_alu_control.sv
// rtl/seq_alu_control.sv - Moore sequencer for shift-add, Booth multiply and restoring divide
module seq_alu_control #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       start,
   input  logic [1:0]                 op,
   input  logic                       q0,
   input  logic                       q_m1,
   input  logic                       acc_sign,
   input  logic                       div_zero,
   output logic                       ld_a,
   output logic                       ld_b,
   output logic                       clr_acc,
   output logic                       add,
   output logic                       sub,
   output logic                       shr,
   output logic                       shl,
   output logic                       set_q0,
   output logic                       out_hi,
   output logic                       out_lo,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [$clog2(WIDTH)-1:0]   iter
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [4:0] {
      S_IDLE    = 5'd0,
      S_LOAD_A  = 5'd1,
      S_LOAD_B  = 5'd2,
      S_INIT    = 5'd3,
      S_TEST    = 5'd4,
      S_ADD     = 5'd5,
      S_SUB     = 5'd6,
      S_SHR     = 5'd7,
      S_SHL     = 5'd8,
      S_DSUB    = 5'd9,
      S_DCHK    = 5'd10,
      S_RESTORE = 5'd11,
      S_SETQ    = 5'd12,
      S_ITER    = 5'd13,
      S_OUT_HI  = 5'd14,
      S_OUT_LO  = 5'd15,
      S_DONE    = 5'd16,
      S_ERR     = 5'd17
   } state_t;

   state_t     state;
   logic [1:0] op_r;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state <= S_IDLE;
         iter  <= '0;
         op_r  <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_LOAD_A;
                  op_r  <= op;
               end
            end
            S_LOAD_A: state <= S_LOAD_B;
            S_LOAD_B: state <= S_INIT;
            S_INIT: begin
               iter <= '0;
               if (op_r == 2'b11 || (op_r == 2'b10 && div_zero))
                  state <= S_ERR;
               else
                  state <= S_TEST;
            end
            S_TEST: begin
               case (op_r)
                  2'b00: state <= q0 ? S_ADD : S_SHR;
                  2'b01: begin
                     // Booth recoding on the {Q[0], q_m1} pair
                     case ({q0, q_m1})
                        2'b01:   state <= S_ADD;
                        2'b10:   state <= S_SUB;
                        default: state <= S_SHR;
                     endcase
                  end
                  default: state <= S_SHL;
               endcase
            end
            S_ADD:     state <= S_SHR;
            S_SUB:     state <= S_SHR;
            S_SHR:     state <= S_ITER;
            S_SHL:     state <= S_DSUB;
            S_DSUB:    state <= S_DCHK;
            S_DCHK:    state <= acc_sign ? S_RESTORE : S_SETQ;
            S_RESTORE: state <= S_ITER;
            S_SETQ:    state <= S_ITER;
            S_ITER: begin
               if (iter == LAST) begin
                  state <= S_OUT_HI;
               end else begin
                  iter  <= iter + 1'b1;
                  state <= S_TEST;
               end
            end
            S_OUT_HI: state <= S_OUT_LO;
            S_OUT_LO: state <= S_DONE;
            S_DONE:   state <= S_IDLE;
            S_ERR:    state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Every output is a pure decode of the state register.
   always_comb begin
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      clr_acc = 1'b0;
      add     = 1'b0;
      sub     = 1'b0;
      shr     = 1'b0;
      shl     = 1'b0;
      set_q0  = 1'b0;
      out_hi  = 1'b0;
      out_lo  = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      busy    = (state != S_IDLE);
      case (state)
         S_LOAD_A:  ld_a    = 1'b1;
         S_LOAD_B:  ld_b    = 1'b1;
         S_INIT:    clr_acc = 1'b1;
         S_ADD:     add     = 1'b1;
         S_SUB:     sub     = 1'b1;
         S_SHR:     shr     = 1'b1;
         S_SHL:     shl     = 1'b1;
         S_DSUB:    sub     = 1'b1;
         S_RESTORE: add     = 1'b1;
         S_SETQ:    set_q0  = 1'b1;
         S_OUT_HI:  out_hi  = 1'b1;
         S_OUT_LO:  out_lo  = 1'b1;
         S_DONE:    done    = 1'b1;
         S_ERR: begin
            err  = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seq_alu_control.sv
// tb/tb_seq_alu_control.sv - directed bench for seq_alu_control at WIDTH 8 and 4
module tb_seq_alu_control;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   // strobe vector bit order: ld_a ld_b clr_acc add sub shr shl set_q0 out_hi out_lo busy done err
   logic        start8, q0_8, qm1_8, accs8, dz8;
   logic [1:0]  op8;
   logic [12:0] s8;
   logic [2:0]  iter8;

   logic        start4, q0_4, qm1_4, accs4, dz4;
   logic [1:0]  op4;
   logic [12:0] s4;
   logic [1:0]  iter4;

   seq_alu_control #(.WIDTH(8)) u8 (
      .clk(clk), .rst_b(rst_b), .start(start8), .op(op8), .q0(q0_8), .q_m1(qm1_8),
      .acc_sign(accs8), .div_zero(dz8),
      .ld_a(s8[0]), .ld_b(s8[1]), .clr_acc(s8[2]), .add(s8[3]), .sub(s8[4]),
      .shr(s8[5]), .shl(s8[6]), .set_q0(s8[7]), .out_hi(s8[8]), .out_lo(s8[9]),
      .busy(s8[10]), .done(s8[11]), .err(s8[12]), .iter(iter8)
   );

   seq_alu_control #(.WIDTH(4)) u4 (
      .clk(clk), .rst_b(rst_b), .start(start4), .op(op4), .q0(q0_4), .q_m1(qm1_4),
      .acc_sign(accs4), .div_zero(dz4),
      .ld_a(s4[0]), .ld_b(s4[1]), .clr_acc(s4[2]), .add(s4[3]), .sub(s4[4]),
      .shr(s4[5]), .shl(s4[6]), .set_q0(s4[7]), .out_hi(s4[8]), .out_lo(s4[9]),
      .busy(s4[10]), .done(s4[11]), .err(s4[12]), .iter(iter4)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int n_add, n_sub, n_shr, n_shl, n_setq, n_err;
   int c_lda, c_ldb, c_clr, c_done, c_idle, hi_iter, multi;

   // Runs one operation on the WIDTH=8 instance and tallies strobes per cycle.
   // mode 0: q0 held 0; 1: Booth pair alternates 01/10; 2: acc_sign alternates 1/0; 3: error path
   task automatic run8(input logic [1:0] o, input int mode, input logic dz);
      int cyc;
      n_add = 0; n_sub = 0; n_shr = 0; n_shl = 0; n_setq = 0; n_err = 0;
      c_lda = 0; c_ldb = 0; c_clr = 0; c_done = 0; c_idle = 0; hi_iter = -1; multi = 0;
      op8 = o; dz8 = dz; q0_8 = 1'b0; qm1_8 = (mode == 1); accs8 = 1'b1;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      cyc = 1;
      for (int k = 0; k < 200; k++) begin
         if (!s8[10]) begin
            c_idle = cyc;
            break;
         end
         if ($countones(s8[9:0]) > 1) multi++;
         if (s8[0] && c_lda == 0) c_lda = cyc;
         if (s8[1] && c_ldb == 0) c_ldb = cyc;
         if (s8[2] && c_clr == 0) c_clr = cyc;
         if (s8[11] && c_done == 0) c_done = cyc;
         if (s8[8]) hi_iter = int'(iter8);
         if (s8[3]) n_add++;
         if (s8[4]) n_sub++;
         if (s8[5]) n_shr++;
         if (s8[6]) n_shl++;
         if (s8[7]) n_setq++;
         if (s8[12]) n_err = cyc;
         if (mode == 1 && s8[5]) {q0_8, qm1_8} = ({q0_8, qm1_8} == 2'b01) ? 2'b10 : 2'b01;
         if (mode == 2 && s8[3]) accs8 = 1'b0;
         if (mode == 2 && s8[7]) accs8 = 1'b1;
         @(negedge clk);
         cyc++;
      end
   endtask

   int cyc4, nd, nl, ni, iter_bad, err4;
   int done_c[3];
   int ld_c[3];
   int idle_c[3];

   initial begin
      rst_b = 1'b0;
      start8 = 1'b0; op8 = 2'b00; q0_8 = 1'b0; qm1_8 = 1'b0; accs8 = 1'b0; dz8 = 1'b0;
      start4 = 1'b0; op4 = 2'b00; q0_4 = 1'b1; qm1_4 = 1'b0; accs4 = 1'b0; dz4 = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs8", s8, 0);
      chk("reset_iter8", iter8, 0);
      chk("reset_outputs4", s4, 0);
      rst_b = 1'b1;

      // reset during the third iteration of an unsigned multiply
      op8 = 2'b00; q0_8 = 1'b0; dz8 = 1'b0;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      n_shr = 0;
      for (int k = 0; k < 100 && n_shr < 2; k++) begin
         if (s8[5]) n_shr++;
         if (n_shr < 2) @(negedge clk);
      end
      chk("pre_reset_shr", n_shr, 2);
      repeat (2) @(negedge clk);
      chk("pre_reset_iter", iter8, 2);
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      chk("mid_reset_busy", s8[10], 0);
      chk("mid_reset_iter", iter8, 0);
      chk("mid_reset_strobes", s8, 0);

      run8(2'b00, 0, 1'b0);
      chk("umul_lda_cycle", c_lda, 1);
      chk("umul_shr", n_shr, 8);
      chk("umul_add", n_add, 0);
      chk("umul_done_cycle", c_done, 30);
      chk("umul_idle_cycle", c_idle, 31);
      chk("umul_onehot", multi, 0);

      run8(2'b01, 1, 1'b0);
      chk("booth_add", n_add, 4);
      chk("booth_sub", n_sub, 4);
      chk("booth_shr", n_shr, 8);
      chk("booth_done_cycle", c_done, 38);
      chk("booth_onehot", multi, 0);

      run8(2'b10, 2, 1'b0);
      chk("div_restore", n_add, 4);
      chk("div_setq", n_setq, 4);
      chk("div_shl", n_shl, 8);
      chk("div_dsub", n_sub, 8);
      chk("div_done_cycle", c_done, 54);
      chk("div_iter_at_hi", hi_iter, 7);
      chk("div_onehot", multi, 0);

      for (int t = 0; t < 2; t++) begin
         run8((t == 0) ? 2'b10 : 2'b11, 3, (t == 0));
         chk("err_lda_cycle", c_lda, 1);
         chk("err_ldb_cycle", c_ldb, 2);
         chk("err_clr_cycle", c_clr, 3);
         chk("err_err_cycle", n_err, 4);
         chk("err_done_cycle", c_done, 4);
         chk("err_idle_cycle", c_idle, 5);
         chk("err_no_datapath", n_add + n_sub + n_shr + n_shl + n_setq, 0);
      end

      // WIDTH=4: start held high, op scrambled while busy
      nd = 0; nl = 0; ni = 0; iter_bad = 0; err4 = 0; cyc4 = 0;
      @(negedge clk) begin start4 = 1'b1; op4 = 2'b00; q0_4 = 1'b1; end
      for (int k = 0; k < 72; k++) begin
         @(negedge clk);
         cyc4++;
         if (s4[0] && nl < 3) begin ld_c[nl] = cyc4; nl++; end
         if (s4[11] && nd < 3) begin done_c[nd] = cyc4; nd++; end
         if (!s4[10] && ni < 3 && nl > ni) begin idle_c[ni] = cyc4; ni++; end
         if (iter4 > 2'd3) iter_bad++;
         if (s4[12]) err4++;
         op4 = s4[10] ? 2'(1 + (cyc4 % 3)) : 2'b00;
         if (cyc4 == 47) start4 = 1'b0;
      end
      chk("w4_runs", nd, 3);
      chk("w4_err", err4, 0);
      chk("w4_iter_range", iter_bad, 0);
      if (nd == 3 && nl == 3 && ni == 3) begin
         chk("w4_done0", done_c[0], 22);
         chk("w4_idle0", idle_c[0], 23);
         chk("w4_lda1", ld_c[1], 24);
         chk("w4_done1", done_c[1], 45);
         chk("w4_lda2", ld_c[2], 47);
         chk("w4_done2", done_c[2], 68);
         chk("w4_idle2", idle_c[2], 69);
      end else begin
         chk("w4_event_count", nd * 100 + nl * 10 + ni, 333);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
